mem_initiator: RTL and testbench

MEM_INITIATOR -- requirements
Module: mem_initiator

---
 rtl/mem_initiator.sv | 154 +++++++++++++++
 tb/tb_mem_initiator.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_initiator.sv
// Single-outstanding load/store initiator bridging a request/response port to
// a memory/IO bus, with sub-word extraction and read-modify-write merging.
module mem_initiator #(
  parameter logic [31:0] IO_BASE = 32'hFFFFFC00,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] caddress,
  output logic [31:0] wdata,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IORead,
  output logic        IOWrite,
  output logic        switchread,
  output logic        ledwrite,
  input  logic [31:0] rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  state_e      state_q;
  logic [31:0] addr_q, wdata_q, resp_rdata_q;
  logic [1:0]  size_q;
  logic        we_q, uns_q, io_q;
  logic [3:0]  cnt_q;
  logic        mem_rd_q, mem_wr_q, io_rd_q, io_wr_q, rvalid_q, rerr_q;

  logic        req_io, req_mis, req_sub;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val, merged;

  always_comb begin
    req_io   = (req_addr >= IO_BASE);
    req_mis  = (req_size == 2'b01 && req_addr[0]) ||
               (req_size[1] && req_addr[1:0] != 2'b00);
    req_sub  = ~req_size[1];
    byte_sel = rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = rdata[{addr_q[1], 4'b0000} +: 16];
    if (io_q || size_q[1])
      load_val = rdata;
    else if (size_q[0])
      load_val = {{16{half_sel[15] & ~uns_q}}, half_sel};
    else
      load_val = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
    // Only meaningful for sub-word memory stores: new lane over the sampled word.
    merged = rdata;
    if (size_q[0])
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_rdata_q <= '0;
      size_q       <= '0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      io_q         <= 1'b0;
      cnt_q        <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      io_rd_q      <= 1'b0;
      io_wr_q      <= 1'b0;
      rvalid_q     <= 1'b0;
      rerr_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          addr_q <= req_addr;
          size_q <= req_size;
          we_q   <= req_we;
          uns_q  <= req_unsigned;
          io_q   <= req_io;
          if (req_we) wdata_q <= req_wdata;
          if (req_mis) begin
            state_q  <= RESP;
            rvalid_q <= 1'b1;
            rerr_q   <= 1'b1;
          end else if (req_we && (req_io || !req_sub)) begin
            state_q <= WR;
            if (req_io) io_wr_q <= 1'b1;
            else        mem_wr_q <= 1'b1;
          end else begin
            state_q <= RD;
            cnt_q   <= 4'(MEM_LAT - 1);
            if (req_io) io_rd_q <= 1'b1;
            else        mem_rd_q <= 1'b1;
          end
        end
        RD: begin
          if (cnt_q == '0) begin
            mem_rd_q <= 1'b0;
            io_rd_q  <= 1'b0;
            if (we_q) begin
              wdata_q  <= merged;
              mem_wr_q <= 1'b1;
              state_q  <= WR;
            end else begin
              resp_rdata_q <= load_val;
              rvalid_q     <= 1'b1;
              rerr_q       <= 1'b0;
              state_q      <= RESP;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        WR: begin
          mem_wr_q <= 1'b0;
          io_wr_q  <= 1'b0;
          rvalid_q <= 1'b1;
          rerr_q   <= 1'b0;
          state_q  <= RESP;
        end
        RESP: begin
          rvalid_q <= 1'b0;
          rerr_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = rvalid_q;
  assign resp_err   = rerr_q;
  assign resp_rdata = resp_rdata_q;
  assign caddress   = io_q ? addr_q : {addr_q[31:2], 2'b00};
  assign wdata      = wdata_q;
  assign MemRead    = mem_rd_q;
  assign MemWrite   = mem_wr_q;
  assign IORead     = io_rd_q;
  assign switchread = io_rd_q;
  assign IOWrite    = io_wr_q;
  assign ledwrite   = io_wr_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator (MEM_LAT=1): hand-computed vectors checked
// with immediate assertions at the falling edge of each cycle.
module tb_mem_initiator;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, caddress, wdata, rdata;
  logic        MemRead, MemWrite, IORead, IOWrite, switchread, ledwrite;
  logic [5:0]  strb;

  int n_cmp = 0;
  int n_err = 0;

  mem_initiator #(.IO_BASE(32'hFFFFFC00), .MEM_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .caddress(caddress), .wdata(wdata),
    .MemRead(MemRead), .MemWrite(MemWrite), .IORead(IORead), .IOWrite(IOWrite),
    .switchread(switchread), .ledwrite(ledwrite), .rdata(rdata)
  );

  // {MemRead, MemWrite, IORead, IOWrite, switchread, ledwrite}
  assign strb = {MemRead, MemWrite, IORead, IOWrite, switchread, ledwrite};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present a request for one edge, then drop req_valid at the next falling edge.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rdata = '0;
    tick(); tick();

    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_caddr", caddress, 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_strb", 32'(strb), 32'h0);

    // Word load at 0x10, accepted on the first edge after reset release
    rst = 1'b0;
    rdata = 32'hDEADBEEF;
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lw_c1_strb", 32'(strb), 32'b100000);
    chk("lw_c1_caddr", caddress, 32'h10);
    chk("lw_c1_ready", 32'(req_ready), 32'd0);
    chk("lw_c1_valid", 32'(resp_valid), 32'd0);
    tick();
    chk("lw_c2_valid", 32'(resp_valid), 32'd1);
    chk("lw_c2_rdata", resp_rdata, 32'hDEADBEEF);
    chk("lw_c2_err", 32'(resp_err), 32'd0);
    chk("lw_c2_strb", 32'(strb), 32'h0);
    tick();
    chk("lw_c3_valid", 32'(resp_valid), 32'd0);
    chk("lw_c3_ready", 32'(req_ready), 32'd1);

    // Signed byte load at 0x13 (lane 3 = 0x80)
    rdata = 32'h80FF1234;
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    chk("lb_c1_caddr", caddress, 32'h10);
    chk("lb_c1_strb", 32'(strb), 32'b100000);
    tick();
    chk("lb_c2_valid", 32'(resp_valid), 32'd1);
    chk("lb_c2_rdata", resp_rdata, 32'hFFFFFF80);
    tick();

    // Unsigned byte load; a store presented mid-flight must be dropped
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    req_we = 1'b1; req_size = 2'b10; req_addr = 32'h40; req_wdata = 32'h12345678;
    req_valid = 1'b1;
    tick();
    chk("lbu_c2_valid", 32'(resp_valid), 32'd1);
    chk("lbu_c2_rdata", resp_rdata, 32'h00000080);
    req_valid = 1'b0;
    tick();
    chk("ignore_c3_strb", 32'(strb), 32'h0);
    chk("ignore_c3_ready", 32'(req_ready), 32'd1);
    tick();
    chk("ignore_c4_strb", 32'(strb), 32'h0);

    // Half store 0xABCD at 0x22 over old word 0x11223344 (read-modify-write)
    rdata = 32'h11223344;
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD);
    chk("sh_c1_strb", 32'(strb), 32'b100000);
    chk("sh_c1_caddr", caddress, 32'h20);
    tick();
    chk("sh_c2_strb", 32'(strb), 32'b010000);
    chk("sh_c2_caddr", caddress, 32'h20);
    chk("sh_c2_wdata", wdata, 32'hABCD3344);
    chk("sh_c2_valid", 32'(resp_valid), 32'd0);
    tick();
    chk("sh_c3_valid", 32'(resp_valid), 32'd1);
    chk("sh_c3_err", 32'(resp_err), 32'd0);
    chk("sh_c3_strb", 32'(strb), 32'h0);
    chk("sh_c3_rdata_hold", resp_rdata, 32'h00000080);
    tick();

    // Misaligned word load at 0x06
    issue(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
    chk("mis_c1_valid", 32'(resp_valid), 32'd1);
    chk("mis_c1_err", 32'(resp_err), 32'd1);
    chk("mis_c1_strb", 32'(strb), 32'h0);
    chk("mis_c1_rdata", resp_rdata, 32'h00000080);
    tick();
    chk("mis_c2_valid", 32'(resp_valid), 32'd0);
    chk("mis_c2_err", 32'(resp_err), 32'd0);
    chk("mis_c2_strb", 32'(strb), 32'h0);

    // IO word store
    issue(1'b1, 2'b10, 1'b0, 32'hFFFFFC60, 32'h00FF00AA);
    chk("iosw_c1_strb", 32'(strb), 32'b000101);
    chk("iosw_c1_caddr", caddress, 32'hFFFFFC60);
    chk("iosw_c1_wdata", wdata, 32'h00FF00AA);
    tick();
    chk("iosw_c2_valid", 32'(resp_valid), 32'd1);
    chk("iosw_c2_strb", 32'(strb), 32'h0);
    tick();

    // IO byte load: address kept unmasked, data passed raw
    rdata = 32'h12345678;
    issue(1'b0, 2'b00, 1'b0, 32'hFFFFFC01, 32'h0);
    chk("iolb_c1_strb", 32'(strb), 32'b001010);
    chk("iolb_c1_caddr", caddress, 32'hFFFFFC01);
    tick();
    chk("iolb_c2_rdata", resp_rdata, 32'h12345678);
    tick();

    // Signed half load at 0x00
    rdata = 32'h12348765;
    issue(1'b0, 2'b01, 1'b0, 32'h00, 32'h0);
    tick();
    chk("lh_c2_rdata", resp_rdata, 32'hFFFF8765);
    tick();

    // Size 11 behaves as a word load
    rdata = 32'hCAFEF00D;
    issue(1'b0, 2'b11, 1'b1, 32'h08, 32'h0);
    tick();
    chk("lw11_c2_rdata", resp_rdata, 32'hCAFEF00D);
    tick();

    // Byte store 0x5A at 0x31 over all-ones
    rdata = 32'hFFFFFFFF;
    issue(1'b1, 2'b00, 1'b0, 32'h31, 32'h0000005A);
    tick();
    chk("sb_c2_strb", 32'(strb), 32'b010000);
    chk("sb_c2_caddr", caddress, 32'h30);
    chk("sb_c2_wdata", wdata, 32'hFFFF5AFF);
    tick();
    chk("sb_c3_valid", 32'(resp_valid), 32'd1);
    tick();

    // Reset during the read phase of a sub-word store aborts it
    issue(1'b1, 2'b00, 1'b0, 32'h41, 32'h00000077);
    chk("abort_c1_strb", 32'(strb), 32'b100000);
    rst = 1'b1;
    tick();
    chk("abort_r_strb", 32'(strb), 32'h0);
    chk("abort_r_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    tick();
    chk("abort_p1_ready", 32'(req_ready), 32'd1);
    chk("abort_p1_strb", 32'(strb), 32'h0);
    chk("abort_p1_valid", 32'(resp_valid), 32'd0);
    tick();
    chk("abort_p2_strb", 32'(strb), 32'h0);
    chk("abort_p2_valid", 32'(resp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
